// File: rtl/stack_lifo.sv
// LIFO stack engine: register-array storage behind a push/pop stack pointer,
// with registered pop data, occupancy tracking, full/empty decode and sticky errors.
module stack_lifo #(
    parameter int BITS       = 8,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [BITS-1:0]       push_data,
    input  logic                  clear_err,
    output logic [BITS-1:0]       pop_data,
    output logic                  pop_valid,
    output logic [DEPTH_BITS-1:0] sp,
    output logic [DEPTH_BITS:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int DEPTH = 2 ** DEPTH_BITS;
    localparam int CW    = DEPTH_BITS + 1;

    typedef logic [DEPTH_BITS-1:0] ptr_t;
    typedef logic [CW-1:0]         cnt_t;

    // Handshake: push/pop are single-cycle requests sampled at each rising edge,
    // there is no ready; refused requests only raise a sticky error. pop_valid is a
    // one-cycle pulse qualifying pop_data, which otherwise holds its last value.

    logic [BITS-1:0] mem_q [DEPTH];

    ptr_t            sp_q, sp_d;
    cnt_t            count_q, count_d;
    logic [BITS-1:0] pop_data_q, pop_data_d;
    logic            pop_valid_q, pop_valid_d;
    logic            err_ov_q, err_ov_d;
    logic            err_un_q, err_un_d;

    logic            mem_we;
    ptr_t            mem_waddr;
    ptr_t            sp_m1;
    logic            is_empty;
    logic            is_full;

    assign sp_m1    = sp_q - ptr_t'(1);
    assign is_empty = (count_q == cnt_t'(0));
    assign is_full  = (count_q == cnt_t'(DEPTH));

    always_comb begin
        sp_d        = sp_q;
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        err_ov_d    = clear_err ? 1'b0 : err_ov_q;
        err_un_d    = clear_err ? 1'b0 : err_un_q;
        mem_we      = 1'b0;
        mem_waddr   = sp_q;

        unique case ({push, pop})
            2'b10: begin
                if (is_full) begin
                    err_ov_d = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = sp_q;
                    sp_d      = sp_q + ptr_t'(1);
                    count_d   = count_q + cnt_t'(1);
                end
            end
            2'b01: begin
                if (is_empty) begin
                    err_un_d = 1'b1;
                end else begin
                    pop_data_d  = mem_q[sp_m1];
                    pop_valid_d = 1'b1;
                    sp_d        = sp_m1;
                    count_d     = count_q - cnt_t'(1);
                end
            end
            2'b11: begin
                pop_valid_d = 1'b1;
                if (is_empty) begin
                    // Bypass: the pushed word goes straight out, storage untouched.
                    pop_data_d = push_data;
                end else begin
                    // Replace-top: the old top is read in the same edge it is overwritten.
                    pop_data_d = mem_q[sp_m1];
                    mem_we     = 1'b1;
                    mem_waddr  = sp_m1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q        <= '0;
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            err_ov_q    <= 1'b0;
            err_un_q    <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            err_ov_q    <= err_ov_d;
            err_un_q    <= err_un_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= push_data;
        end
    end

    assign pop_data      = pop_data_q;
    assign pop_valid     = pop_valid_q;
    assign sp            = sp_q;
    assign count         = count_q;
    assign empty         = is_empty;
    assign full          = is_full;
    assign err_overflow  = err_ov_q;
    assign err_underflow = err_un_q;

endmodule

// File: tb/tb_stack_lifo.sv
// Bench for stack_lifo: queue-based stack model checked every cycle, directed
// scenarios with literal expectations, then randomized push/pop/clear/reset traffic.
module tb_stack_lifo;

    localparam int BITS       = 8;
    localparam int DEPTH_BITS = 2;
    localparam int DEPTH      = 2 ** DEPTH_BITS;

    logic                  clk;
    logic                  rst;
    logic                  push;
    logic                  pop;
    logic [BITS-1:0]       push_data;
    logic                  clear_err;
    logic [BITS-1:0]       pop_data;
    logic                  pop_valid;
    logic [DEPTH_BITS-1:0] sp;
    logic [DEPTH_BITS:0]   count;
    logic                  empty;
    logic                  full;
    logic                  err_overflow;
    logic                  err_underflow;

    stack_lifo #(.BITS(BITS), .DEPTH_BITS(DEPTH_BITS)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
        .clear_err(clear_err), .pop_data(pop_data), .pop_valid(pop_valid),
        .sp(sp), .count(count), .empty(empty), .full(full),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [BITS-1:0] stk[$];
    logic [BITS-1:0] m_pd;
    logic            m_pv;
    logic            m_ov;
    logic            m_un;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stk.delete();
            m_pd = '0;
            m_pv = 1'b0;
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            logic ov_set;
            logic un_set;
            ov_set = 1'b0;
            un_set = 1'b0;
            m_pv   = 1'b0;
            if (push && pop) begin
                m_pv = 1'b1;
                if (stk.size() > 0) begin
                    m_pd = stk[stk.size()-1];
                    stk[stk.size()-1] = push_data;
                end else begin
                    m_pd = push_data;
                end
            end else if (push) begin
                if (stk.size() < DEPTH) stk.push_back(push_data);
                else ov_set = 1'b1;
            end else if (pop) begin
                if (stk.size() > 0) begin
                    m_pd = stk.pop_back();
                    m_pv = 1'b1;
                end else begin
                    un_set = 1'b1;
                end
            end
            m_ov = ov_set | (m_ov & ~clear_err);
            m_un = un_set | (m_un & ~clear_err);
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec;
    int n_err;
    bit chk_en;
    logic [BITS-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pops the next expected word from the directed expectation queue.
    task automatic check_pop(input string name);
        logic [BITS-1:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_expq_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check(name, int'(pop_data), int'(e));
            check({name, "_valid"}, int'(pop_valid), 1);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("count", int'(count), stk.size());
            check("sp", int'(sp), stk.size() % DEPTH);
            check("empty", int'(empty), int'(stk.size() == 0));
            check("full", int'(full), int'(stk.size() == DEPTH));
            check("pop_valid", int'(pop_valid), int'(m_pv));
            check("pop_data", int'(pop_data), int'(m_pd));
            check("err_overflow", int'(err_overflow), int'(m_ov));
            check("err_underflow", int'(err_underflow), int'(m_un));
        end
    end

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic p, input logic q, input logic [BITS-1:0] d, input logic c);
        push      = p;
        pop       = q;
        push_data = d;
        clear_err = c;
        @(negedge clk);
        push      = 1'b0;
        pop       = 1'b0;
        clear_err = 1'b0;
    endtask

    initial begin
        logic [BITS-1:0] pat [4];
        n_vec = 0;
        n_err = 0;
        chk_en = 1'b0;
        rst = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        push_data = '0;
        clear_err = 1'b0;
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state, then idle
        repeat (3) step(1'b0, 1'b0, '0, 1'b0);
        check("rst_sp", int'(sp), 0);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_pv", int'(pop_valid), 0);
        check("rst_pd", int'(pop_data), 0);
        check("rst_errs", int'({err_overflow, err_underflow}), 0);

        // Fill, then overflow
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, pat[i], 1'b0);
            check("fill_count", int'(count), i + 1);
            check("fill_sp", int'(sp), (i + 1) % 4);
        end
        check("fill_full", int'(full), 1);
        step(1'b1, 1'b0, 8'h55, 1'b0);
        check("ovf_count", int'(count), 4);
        check("ovf_flag", int'(err_overflow), 1);

        // Drain, then underflow
        exp_q = '{8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, '0, 1'b0);
            check_pop("drain_pd");
            check("drain_count", int'(count), 3 - i);
        end
        check("drain_empty", int'(empty), 1);
        step(1'b0, 1'b0, '0, 1'b0);
        check("pv_pulse_drop", int'(pop_valid), 0);
        step(1'b0, 1'b1, '0, 1'b0);
        check("udf_flag", int'(err_underflow), 1);
        check("udf_pv", int'(pop_valid), 0);
        check("udf_pd_held", int'(pop_data), 8'h11);

        // Replace-top
        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        exp_q = '{8'h22, 8'hAA, 8'h11};
        step(1'b1, 1'b1, 8'hAA, 1'b0);
        check_pop("rt_pd");
        check("rt_count", int'(count), 2);
        step(1'b0, 1'b1, '0, 1'b0);
        check_pop("rt_pop1");
        step(1'b0, 1'b1, '0, 1'b0);
        check_pop("rt_pop2");

        // Bypass on empty
        step(1'b0, 1'b0, '0, 1'b1);
        check("clr_errs", int'({err_overflow, err_underflow}), 0);
        exp_q = '{8'h5C};
        step(1'b1, 1'b1, 8'h5C, 1'b0);
        check_pop("byp_pd");
        check("byp_count", int'(count), 0);
        check("byp_errs", int'({err_overflow, err_underflow}), 0);

        // Async reset between edges, the cycle after a pop
        step(1'b1, 1'b0, 8'h77, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_pv", int'(pop_valid), 0);
        check("arst_count", int'(count), 0);
        @(negedge clk);
        rst = 1'b0;

        // Errors, set-wins-over-clear, then clear
        step(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        check("err_both", int'({err_overflow, err_underflow}), 3);
        step(1'b1, 1'b0, 8'h99, 1'b1);
        check("setwins_ov", int'(err_overflow), 1);
        check("setwins_un", int'(err_underflow), 0);
        step(1'b0, 1'b0, '0, 1'b1);
        check("clr_both", int'({err_overflow, err_underflow}), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 45,
                     8'($urandom), $urandom_range(0, 19) == 0);
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
